// File: rtl/spr_pixel_writer.sv
`default_nettype none
// ============================================================================
// Module   : spr_pixel_writer
// Purpose  : Sprite tile pixel writer. Latches a 16-pixel, 4 bpp tile row and,
//            over 8 clock-enabled steps, emits up to two line-buffer writes per
//            step. KEEP_A/KEEP_B come from the shrink generator. Kept pixels are
//            packed onto consecutive 9-bit addresses that wrap modulo 512.
//            Colour 0 is transparent: it takes an address but raises no strobe.
// Ports    : clk, rst_n                 clock, async active-low reset
//            ck_en_i, load_i            pixel-pair enable, tile start
//            x_pos_i, pal_i, gfx_i      tile start X, palette, 16x4-bit pixels
//            flip_h_i                   horizontal flip
//            keep_a_i, keep_b_i         shrink keep flags for the current pair
//            we_a_o/we_b_o              one-cycle write strobes, lanes A/B
//            addr_a_o/addr_b_o          line-buffer addresses
//            data_a_o/data_b_o          {palette, colour}
//            busy_o, done_o             tile in progress, completion pulse
// Revision : 1.0  initial release
// ============================================================================
module spr_pixel_writer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ck_en_i,
  input  logic        load_i,
  input  logic [8:0]  x_pos_i,
  input  logic [7:0]  pal_i,
  input  logic [63:0] gfx_i,
  input  logic        flip_h_i,
  input  logic        keep_a_i,
  input  logic        keep_b_i,
  output logic        we_a_o,
  output logic        we_b_o,
  output logic [8:0]  addr_a_o,
  output logic [8:0]  addr_b_o,
  output logic [11:0] data_a_o,
  output logic [11:0] data_b_o,
  output logic        busy_o,
  output logic        done_o
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [63:0] gfx_q,   gfx_d;
  logic [7:0]  pal_q,   pal_d;
  logic        flip_q,  flip_d;
  logic [8:0]  x_q,     x_d;
  logic [2:0]  s_q,     s_d;
  logic        we_a_q,  we_a_d;
  logic        we_b_q,  we_b_d;
  logic [8:0]  addr_a_q, addr_a_d;
  logic [8:0]  addr_b_q, addr_b_d;
  logic [11:0] data_a_q, data_a_d;
  logic [11:0] data_b_q, data_b_d;
  logic        done_q,  done_d;

  // Pixel selection for the current pair.
  logic [3:0] idx_first, idx_second;
  logic [3:0] col_first, col_second;
  logic [8:0] x_plus1;

  always_comb begin
    idx_first  = flip_q ? (4'd15 - {s_q, 1'b0}) : {s_q, 1'b0};
    idx_second = flip_q ? (4'd14 - {s_q, 1'b0}) : {s_q, 1'b1};
    col_first  = gfx_q[{idx_first, 2'b00} +: 4];
    col_second = gfx_q[{idx_second, 2'b00} +: 4];
    x_plus1    = x_q + 9'd1;
  end

  always_comb begin
    state_d  = state_q;
    gfx_d    = gfx_q;
    pal_d    = pal_q;
    flip_d   = flip_q;
    x_d      = x_q;
    s_d      = s_q;
    addr_a_d = addr_a_q;
    addr_b_d = addr_b_q;
    data_a_d = data_a_q;
    data_b_d = data_b_q;
    // Strobes and DONE are single-cycle pulses, independent of ck_en spacing.
    we_a_d   = 1'b0;
    we_b_d   = 1'b0;
    done_d   = 1'b0;

    if (ck_en_i) begin
      if (load_i) begin
        // Start (or abort and restart) a tile; no write on this edge.
        state_d = ST_BUSY;
        gfx_d   = gfx_i;
        pal_d   = pal_i;
        flip_d  = flip_h_i;
        x_d     = x_pos_i;
        s_d     = 3'd0;
      end else if (state_q == ST_BUSY) begin
        addr_a_d = x_q;
        addr_b_d = x_plus1;
        case ({keep_a_i, keep_b_i})
          2'b11: begin
            data_a_d = {pal_q, col_first};
            data_b_d = {pal_q, col_second};
            we_a_d   = (col_first  != 4'd0);
            we_b_d   = (col_second != 4'd0);
            x_d      = x_q + 9'd2;
          end
          2'b10: begin
            data_a_d = {pal_q, col_first};
            we_a_d   = (col_first != 4'd0);
            x_d      = x_plus1;
          end
          2'b01: begin
            // A lone kept pixel always goes out on lane A.
            data_a_d = {pal_q, col_second};
            we_a_d   = (col_second != 4'd0);
            x_d      = x_plus1;
          end
          default: ;
        endcase
        s_d = s_q + 3'd1;
        if (s_q == 3'd7) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      gfx_q    <= 64'd0;
      pal_q    <= 8'd0;
      flip_q   <= 1'b0;
      x_q      <= 9'd0;
      s_q      <= 3'd0;
      we_a_q   <= 1'b0;
      we_b_q   <= 1'b0;
      addr_a_q <= 9'd0;
      addr_b_q <= 9'd0;
      data_a_q <= 12'd0;
      data_b_q <= 12'd0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      gfx_q    <= gfx_d;
      pal_q    <= pal_d;
      flip_q   <= flip_d;
      x_q      <= x_d;
      s_q      <= s_d;
      we_a_q   <= we_a_d;
      we_b_q   <= we_b_d;
      addr_a_q <= addr_a_d;
      addr_b_q <= addr_b_d;
      data_a_q <= data_a_d;
      data_b_q <= data_b_d;
      done_q   <= done_d;
    end
  end

  assign we_a_o   = we_a_q;
  assign we_b_o   = we_b_q;
  assign addr_a_o = addr_a_q;
  assign addr_b_o = addr_b_q;
  assign data_a_o = data_a_q;
  assign data_b_o = data_b_q;
  assign busy_o   = (state_q == ST_BUSY);
  assign done_o   = done_q;

endmodule
`default_nettype wire
